// File: rtl/adder_tree_feeder.sv
// Serial-to-parallel operand feeder for a pipelined CSA adder tree: collects I_DATA_N words,
// waits TREE_LAT cycles for the tree, then holds the captured sum until downstream takes it.
module adder_tree_feeder #(
    parameter int unsigned I_DATA_W = 3,
    parameter int unsigned I_DATA_N = 4,
    parameter int unsigned TREE_LAT = 2,
    parameter int unsigned SUM_W    = 6
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [I_DATA_W-1:0]                i_data,
    output logic [0:I_DATA_N-1][I_DATA_W-1:0]  o_tree_data,
    input  logic [SUM_W-1:0]                   i_tree_sum,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [SUM_W-1:0]                   o_data,
    output logic                               o_busy
);

    localparam int unsigned CNT_W = $clog2(I_DATA_N);
    localparam int unsigned LAT_W = 4;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(I_DATA_N - 1);
    localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(TREE_LAT);

    if (SUM_W < I_DATA_W + $clog2(I_DATA_N) || I_DATA_N < 3 || I_DATA_N > 32 ||
        TREE_LAT < 1 || TREE_LAT > 15) begin : g_bad_params
        $error("adder_tree_feeder: illegal parameter combination");
    end

    typedef enum logic [1:0] {StCollect, StWait, StHold} state_e;

    state_e                              r_state;
    state_e                              w_state_next;
    logic [CNT_W-1:0]                    r_word_cnt;
    logic [LAT_W-1:0]                    r_lat_cnt;
    logic [0:I_DATA_N-1][I_DATA_W-1:0]   r_tree_data;
    logic [SUM_W-1:0]                    r_data;
    logic                                r_valid;

    logic w_accept;
    logic w_last;
    logic w_capture;
    logic w_release;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        o_ready      = 1'b0;
        o_busy       = 1'b0;
        unique case (r_state)
            StCollect: begin
                o_ready  = 1'b1;
                w_accept = i_valid;
                w_last   = i_valid && (r_word_cnt == LAST_IDX);
                if (w_last) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                o_busy    = 1'b1;
                w_capture = (r_lat_cnt == LAT_END);
                if (w_capture) begin
                    w_state_next = StHold;
                end
            end
            StHold: begin
                o_busy    = 1'b1;
                w_release = i_ready;
                if (w_release) begin
                    w_state_next = StCollect;
                end
            end
            default: w_state_next = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StCollect;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand slots are only ever written on accept, so they stay frozen through WAIT/HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word_cnt  <= '0;
            r_lat_cnt   <= '0;
            r_tree_data <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tree_data[r_word_cnt] <= i_data;
                r_word_cnt <= w_last ? '0 : r_word_cnt + CNT_W'(1);
            end
            if (w_last) begin
                r_lat_cnt <= '0;
            end else if (r_state == StWait && !w_capture) begin
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end
            if (w_capture) begin
                r_data  <= i_tree_sum;
                r_valid <= 1'b1;
            end else if (w_release) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_tree_data = r_tree_data;
    assign o_data      = r_data;
    assign o_valid     = r_valid;

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Scoreboard bench for adder_tree_feeder: directed operations push expected sums, a monitor
// pops and compares on every output handshake; the tree is modelled as a registered sum.
module tb_adder_tree_feeder;

    localparam int unsigned I_DATA_W = 3;
    localparam int unsigned I_DATA_N = 4;
    localparam int unsigned TREE_LAT = 2;
    localparam int unsigned SUM_W    = 6;

    typedef logic [I_DATA_W-1:0] word_t;
    typedef logic [0:I_DATA_N-1][I_DATA_W-1:0] vec_t;
    typedef word_t op_t [I_DATA_N];

    logic             clk;
    logic             rst_n;
    logic             i_valid;
    logic             o_ready;
    word_t            i_data;
    vec_t             o_tree_data;
    logic [SUM_W-1:0] i_tree_sum;
    logic             o_valid;
    logic             i_ready;
    logic [SUM_W-1:0] o_data;
    logic             o_busy;

    adder_tree_feeder #(
        .I_DATA_W (I_DATA_W),
        .I_DATA_N (I_DATA_N),
        .TREE_LAT (TREE_LAT),
        .SUM_W    (SUM_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .o_tree_data (o_tree_data),
        .i_tree_sum  (i_tree_sum),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder tree model: TREE_LAT-stage registered sum of the operand vector.
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] pipe [TREE_LAT];
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < I_DATA_N; k++) w_sum = w_sum + SUM_W'(o_tree_data[k]);
    end
    always @(posedge clk) begin
        pipe[0] <= w_sum;
        for (int k = 1; k < TREE_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign i_tree_sum = pipe[TREE_LAT-1];

    int total = 0;
    int bad   = 0;
    logic [SUM_W-1:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest outstanding sum.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got o_valid=1 o_data=%0d, expected no output", o_data);
            end else begin
                chk("o_data", 64'(o_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input word_t w);
        i_valid = 1'b1;
        i_data  = w;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (o_ready) break;
        end
        chk("accept_ready", 64'(o_ready), 64'd1);
        step();
        i_valid = 1'b0;
    endtask

    task automatic run_op(input op_t w, input logic [SUM_W-1:0] s);
        for (int k = 0; k < I_DATA_N; k++) send_word(w[k]);
        exp_q.push_back(s);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 50) begin
            step();
            n++;
            if (o_valid) break;
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int c, input int d);
        vec_t v;
        v[0] = word_t'(a);
        v[1] = word_t'(b);
        v[2] = word_t'(c);
        v[3] = word_t'(d);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        op_t op;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_ready = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_o_ready", 64'(o_ready), 64'd1);
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_busy", 64'(o_busy), 64'd0);
        chk("rst_o_data", 64'(o_data), 64'd0);
        chk("rst_tree", 64'(o_tree_data), 64'(mk(0, 0, 0, 0)));

        // Basic operation and latency.
        step();
        op = '{3'd1, 3'd2, 3'd3, 3'd4};
        run_op(op, 6'd10);
        chk("tree_1234", 64'(o_tree_data), 64'(mk(1, 2, 3, 4)));
        chk("busy_wait", 64'(o_busy), 64'd1);
        wait_valid(n);
        chk("latency", 64'(n), 64'(TREE_LAT + 1));
        chk("data_10", 64'(o_data), 64'd10);
        step();
        chk("valid_one_cycle", 64'(o_valid), 64'd0);
        chk("ready_after", 64'(o_ready), 64'd1);

        // Gaps between words; untouched slots keep previous values.
        for (int k = 0; k < I_DATA_N; k++) begin
            send_word(3'd7);
            if (k == I_DATA_N - 1) begin
                exp_q.push_back(6'd28);
            end else begin
                repeat (2) step();
                if (k == 0) chk("tree_gap", 64'(o_tree_data), 64'(mk(7, 2, 3, 4)));
            end
        end
        wait_valid(n);
        chk("data_28", 64'(o_data), 64'd28);
        chk("tree_7777", 64'(o_tree_data), 64'(mk(7, 7, 7, 7)));
        step();

        // Back-pressure in HOLD with i_valid held high.
        i_ready = 1'b0;
        op = '{3'd1, 3'd1, 3'd1, 3'd2};
        run_op(op, 6'd5);
        i_valid = 1'b1;
        i_data  = 3'd3;
        wait_valid(n);
        chk("hold_latency", 64'(n), 64'(TREE_LAT + 1));
        repeat (6) begin
            @(negedge clk);
            chk("hold_valid", 64'(o_valid), 64'd1);
            chk("hold_data", 64'(o_data), 64'd5);
            chk("hold_ready", 64'(o_ready), 64'd0);
            chk("hold_tree", 64'(o_tree_data), 64'(mk(1, 1, 1, 2)));
        end
        step();
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        chk("release_valid", 64'(o_valid), 64'd0);
        chk("release_ready", 64'(o_ready), 64'd1);
        chk("release_data", 64'(o_data), 64'd5);
        step();
        i_valid = 1'b0;
        chk("slot0_after_hold", 64'(o_tree_data), 64'(mk(3, 1, 1, 2)));
        i_ready = 1'b1;
        send_word(3'd0);
        send_word(3'd0);
        send_word(3'd0);
        exp_q.push_back(6'd3);
        wait_valid(n);
        step();

        // Back-to-back operations.
        op = '{3'd1, 3'd1, 3'd1, 3'd1};
        run_op(op, 6'd4);
        op = '{3'd2, 3'd0, 3'd0, 3'd0};
        run_op(op, 6'd2);
        op = '{3'd7, 3'd0, 3'd7, 3'd0};
        run_op(op, 6'd14);
        wait_valid(n);
        chk("b2b_last", 64'(o_data), 64'd14);
        step();

        // Reset during WAIT discards the operation.
        send_word(3'd5);
        send_word(3'd5);
        send_word(3'd5);
        send_word(3'd5);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("wrst_tree", 64'(o_tree_data), 64'(mk(0, 0, 0, 0)));
        chk("wrst_ready", 64'(o_ready), 64'd1);
        chk("wrst_busy", 64'(o_busy), 64'd0);
        chk("wrst_data", 64'(o_data), 64'd0);
        repeat (6) begin
            @(negedge clk);
            chk("wrst_no_valid", 64'(o_valid), 64'd0);
        end

        // Reset mid-collection, then a fresh operation.
        step();
        send_word(3'd5);
        send_word(3'd6);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        op = '{3'd0, 3'd1, 3'd0, 3'd1};
        run_op(op, 6'd2);
        wait_valid(n);
        chk("crst_data", 64'(o_data), 64'd2);
        chk("crst_tree", 64'(o_tree_data), 64'(mk(0, 1, 0, 1)));
        repeat (3) step();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
